gate_sweep_checker: RTL and testbench

//  Self-checking sweep engine for the basic-gate library. Drives every input

---
 rtl/gate_sweep_checker.sv | 120 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus sweep and golden-function checker for up to N_DUT parallel gate models.
// Every vector is held SETTLE cycles and then sampled for one CHECK cycle; the results stay valid in DONE.
module gate_sweep_checker #(
  parameter int N_IN    = 2,
  parameter int N_DUT   = 3,
  parameter int SETTLE  = 2,
  parameter int GATE_OP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_DUT-1:0]  dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_DUT-1:0]  fail_mask,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    settle_cnt;
  logic             golden;
  logic [N_DUT-1:0] mis;
  logic             any_mis;
  logic [N_IN:0]    err_next;

  always_comb begin
    golden = 1'b0;
    case (GATE_OP)
      0:       golden =   &stim;
      1:       golden =   |stim;
      2:       golden =   ^stim;
      3:       golden = ~(&stim);
      4:       golden = ~(|stim);
      5:       golden = ~(^stim);
      default: golden = 1'b0;
    endcase
  end

  // Case inequality, so a model output of X or Z is counted as a mismatch in 4-state simulation.
  always_comb begin
    mis = '0;
    for (int unsigned i = 0; i < N_DUT; i++) begin
      mis[i] = (dut_y[i] !== golden);
    end
  end

  assign any_mis  = |mis;
  assign err_next = err_count + {{N_IN{1'b0}}, any_mis};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      settle_cnt     <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_mask      <= '0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            stim           <= '0;
            err_count      <= '0;
            fail_mask      <= '0;
            first_fail_vec <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            settle_cnt     <= CW'(SETTLE - 1);
            state          <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (any_mis) begin
            err_count <= err_next;
            fail_mask <= fail_mask | mis;
            if (err_count == '0) begin
              first_fail_vec <= stim;
            end
          end
          // pass is computed from err_next so that it agrees with the final err_count when done rises.
          if (&stim) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
            state <= ST_DONE;
          end else begin
            stim       <= stim + 1'b1;
            settle_cnt <= CW'(SETTLE - 1);
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: the driver queues the expected sweep results
// and the done-edge monitors compare them against what the DUT reports.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [1:0] stim_a;
  logic [2:0] dut_y_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [2:0] mask_a;
  logic [1:0] ffv_a;
  logic [2:0] stim_b;
  logic [2:0] dut_y_b;
  logic       busy_b, done_b, pass_b;
  logic [3:0] err_b;
  logic [2:0] mask_b;
  logic [2:0] ffv_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mode   = 0;

  typedef struct {
    int err;
    int mask;
    int ffv;
    int pass;
    int lat;
    int s;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  bit   done_prev_a = 1'b0;
  bit   done_prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_sweep_checker u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .dut_y(dut_y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_mask(mask_a), .first_fail_vec(ffv_a)
  );

  gate_sweep_checker #(.N_IN(3), .N_DUT(3), .SETTLE(1), .GATE_OP(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .dut_y(dut_y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_mask(mask_b), .first_fail_vec(ffv_b)
  );

  // Gate models for u_a (AND). Verilator is 2-state, so model 2's X on vector 01 is stood in for by the wrong level.
  always_comb begin
    dut_y_a = {3{&stim_a}};
    case (mode)
      1: dut_y_a[1] = 1'b0;
      2: begin
        dut_y_a[0] = ~(&stim_a);
        if (stim_a == 2'b01) dut_y_a[2] = 1'b1;
      end
      default: ;
    endcase
  end

  assign dut_y_b = {3{^stim_b}};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int err, input int mask, input int ffv, input int pass, input int lat);
    exp_t e;
    e.err = err; e.mask = mask; e.ffv = ffv; e.pass = pass; e.lat = lat; e.s = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done_a && !done_prev_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        ea = q_a.pop_front();
        chk("a_latency",   cyc - ea.s, ea.lat);
        chk("a_err_count", int'(err_a),  ea.err);
        chk("a_fail_mask", int'(mask_a), ea.mask);
        chk("a_first_fail", int'(ffv_a), ea.ffv);
        chk("a_pass",      int'(pass_a), ea.pass);
        chk("a_busy_done", int'(busy_a), 0);
      end
    end
    done_prev_a = done_a;
  end

  always @(negedge clk) begin
    if (done_b && !done_prev_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        eb = q_b.pop_front();
        chk("b_latency",   cyc - eb.s, eb.lat);
        chk("b_err_count", int'(err_b),  eb.err);
        chk("b_fail_mask", int'(mask_b), eb.mask);
        chk("b_first_fail", int'(ffv_b), eb.ffv);
        chk("b_pass",      int'(pass_b), eb.pass);
        chk("b_busy_done", int'(busy_b), 0);
      end
    end
    done_prev_b = done_b;
  end

  // Returns #1 after the edge that sampled start.
  task automatic pulse_start(input bit which, input bit push, input exp_t e);
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    e.s = cyc;
    if (push) begin
      if (which) q_b.push_back(e); else q_a.push_back(e);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (q_a.size() == 0 && q_b.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", int'(ok), 1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_stim"},  int'(stim_a), 0);
    chk({tag, "_busy"},  int'(busy_a), 0);
    chk({tag, "_done"},  int'(done_a), 0);
    chk({tag, "_pass"},  int'(pass_a), 0);
    chk({tag, "_err"},   int'(err_a),  0);
    chk({tag, "_mask"},  int'(mask_a), 0);
    chk({tag, "_ffv"},   int'(ffv_a),  0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_a("t1_reset");
    chk("t1_b_done", int'(done_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T2: correct models, stimulus held 3 cycles per vector
    mode = 0;
    pulse_start(1'b0, 1'b1, mk(0, 0, 0, 1, 12));
    for (int k = 0; k < 12; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("t2_stim_k%0d", k), int'(stim_a), k / 3);
      chk($sformatf("t2_busy_k%0d", k), int'(busy_a), 1);
    end
    wait_drain();
    chk("t2_done_held", int'(done_a), 1);

    // T3: model 1 stuck-at-0 fails only on 11
    mode = 1;
    pulse_start(1'b0, 1'b1, mk(1, 3'b010, 3, 0, 12));
    wait_drain();

    // T4: model 0 inverted, model 2 wrong on 01
    mode = 2;
    pulse_start(1'b0, 1'b1, mk(4, 3'b101, 0, 0, 12));
    wait_drain();

    // T5a: start re-pulsed while busy has no effect
    mode = 0;
    pulse_start(1'b0, 1'b1, mk(0, 0, 0, 1, 12));
    pulse_start(1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    chk("t5_busy_repulse", int'(busy_a), 1);
    repeat (3) @(negedge clk);
    pulse_start(1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    wait_drain();

    // T5b: reset mid-sweep, then a clean sweep
    mode = 1;
    pulse_start(1'b0, 1'b1, mk(0, 0, 0, 0, 12));
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_a("t5_midreset");
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    pulse_start(1'b0, 1'b1, mk(0, 0, 0, 1, 12));
    wait_drain();

    // T6: 3-input XOR, SETTLE=1; restart from DONE clears done on the next cycle
    pulse_start(1'b1, 1'b1, mk(0, 0, 0, 1, 16));
    wait_drain();
    chk("t6_done_before", int'(done_b), 1);
    pulse_start(1'b1, 1'b1, mk(0, 0, 0, 1, 16));
    chk("t6_done_cleared", int'(done_b), 0);
    chk("t6_busy_restart", int'(busy_b), 1);
    chk("t6_stim_restart", int'(stim_b), 0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
